// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int START_DIV = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/uart_rx_sff.sv
// Generic synchronous FIFO with a registered, strobed read port.
module uart_rx_sff #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              rdVld,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
    $error("uart_rx_sff: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    count;
  logic              doPush;
  logic              doPop;

  // Fullness is judged on the pre-edge count, so a push into a full FIFO is dropped even alongside a pop
  assign empty  = (count == '0);
  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      rdVld  <= 1'b0;
      rdData <= '0;
    end else begin
      rdVld <= doPop;
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) begin
        rdPtr  <= rdPtr + 1'b1;
        rdData <= mem[rdPtr];
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/uart_rx_ff.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a receive FIFO,
// with sticky frame/overrun/parity error flags.
module uart_rx_ff
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstB,
  input  logic       rxSerial,
  input  logic       rxRdEn,
  output logic [7:0] rxData,
  output logic       uartOutEn,
  output logic       rxFfEmpty,
  output logic       rxFfFull,
  input  logic       rxErrClr,
  output logic       rxFrameErr,
  output logic       rxOverrun,
  output logic       rxParityErr
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / START_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : gCpbCheck
    $error("uart_rx_ff: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic                 rxSync_p0;
  logic                 rxSync_p1;
  uart_rx_state_t       state;
  logic [CNT_W-1:0]     bitCnt;
  logic [BIT_W-1:0]     bitIdx;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 pushVld_p0;
  logic                 parityOk;
  logic                 bitEnd;
  logic                 frameErrSet;
  logic                 overrunSet;

  // Stage p0/p1: two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      rxSync_p0 <= 1'b1;
      rxSync_p1 <= 1'b1;
    end else begin
      rxSync_p0 <= rxSerial;
      rxSync_p1 <= rxSync_p0;
    end
  end

  assign bitEnd = (bitCnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic parityBit;
  logic parityErrSet;

  assign parityOk     = ~^{shiftReg, parityBit};
  assign parityErrSet = (state == STOP) && bitEnd && rxSync_p1 && !parityOk;

  always_ff @(posedge clk) begin
    if (state == PARITY && bitEnd) parityBit <= rxSync_p1;
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) rxParityErr <= 1'b0;
    else       rxParityErr <= parityErrSet | (rxParityErr & ~rxErrClr);
  end
`else
  assign parityOk    = 1'b1;
  assign rxParityErr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (state == DATA && bitEnd) shiftReg <= {rxSync_p1, shiftReg[DATA_BITS-1:1]};
  end

  // Deframing FSM; stage p0 holds the registered push of a completed byte
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state      <= IDLE;
      bitCnt     <= '0;
      bitIdx     <= '0;
      pushVld_p0 <= 1'b0;
    end else begin
      pushVld_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxSync_p1) begin
            state  <= START;
            bitCnt <= '0;
          end
        end
        START: begin
          if (bitCnt == CNT_HALF) begin
            bitCnt <= '0;
            bitIdx <= '0;
            state  <= rxSync_p1 ? IDLE : DATA;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            bitCnt <= '0;
            bitIdx <= bitIdx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bitIdx == BIT_LAST) state <= PARITY;
`else
            if (bitIdx == BIT_LAST) state <= STOP;
`endif
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bitEnd) begin
            bitCnt <= '0;
            state  <= STOP;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bitEnd) begin
            bitCnt <= '0;
            if (!rxSync_p1) begin
              state <= WAIT_HIGH;
            end else begin
              state      <= IDLE;
              pushVld_p0 <= parityOk;
            end
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxSync_p1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frameErrSet = (state == STOP) && bitEnd && !rxSync_p1;
  assign overrunSet  = pushVld_p0 && rxFfFull;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      rxFrameErr <= 1'b0;
      rxOverrun  <= 1'b0;
    end else begin
      rxFrameErr <= frameErrSet | (rxFrameErr & ~rxErrClr);
      rxOverrun  <= overrunSet  | (rxOverrun  & ~rxErrClr);
    end
  end

  uart_rx_sff #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) uRxFifo (
    .clk    (clk),
    .rstB   (rstB),
    .push   (pushVld_p0),
    .pop    (rxRdEn),
    .wrData (shiftReg),
    .rdData (rxData),
    .rdVld  (uartOutEn),
    .empty  (rxFfEmpty),
    .full   (rxFfFull)
  );

endmodule

// File: doc/uart_rx_ff.md
# uart_rx_ff

Serial UART receiver with an integrated receive FIFO, sitting directly upstream of the boot programmer. It samples the asynchronous `rxSerial` line and deframes 8N1 bytes, or 8E1 bytes when parity is compiled in. Each good byte is pushed into a small synchronous FIFO. The FIFO is drained by a single-cycle read handshake: `rxRdEn`, then `uartOutEn` with `rxData` one cycle later. Error conditions are captured in sticky flags.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock in Hz.
- `BAUD_RATE`, 115200: line bit rate.
- `FIFO_DEPTH`, 16: receive FIFO entries. Power of two, at least 2.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rstB`  in  1  asynchronous, active-low reset.
- `rxSerial`  in  1  UART line. Idles high. Asynchronous to `clk`.
- `rxRdEn`  in  1  FIFO pop request.
- `rxData`  out  8  popped byte. Valid while `uartOutEn`=1.
- `uartOutEn`  out  1  one-cycle strobe marking valid `rxData`.
- `rxFfEmpty`  out  1  FIFO holds 0 entries.
- `rxFfFull`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `rxErrClr`  in  1  clears all sticky error flags.
- `rxFrameErr`  out  1  sticky: stop bit sampled 0.
- `rxOverrun`  out  1  sticky: completed byte dropped because the FIFO was full.
- `rxParityErr`  out  1  sticky: parity mismatch. Constant 0 without parity.

## Operation
- `CLKS_PER_BIT` = `CLK_FREQ`/`BAUD_RATE`, integer-truncated. It must be at least 4; elaboration fails otherwise.
- The bit counter is `$clog2(CLKS_PER_BIT)` wide and wraps at `CLKS_PER_BIT`-1.
- `rxSerial` passes through a 2-flop synchronizer. Both flops reset to 1. All FSM decisions use the synchronized value.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on synchronized 0, go to START and clear the counter.
  - START: at count `CLKS_PER_BIT`/2, re-sample the line.
    - If 1 (glitch), go to IDLE.
    - If 0, go to DATA and clear the counter.
  - DATA: sample at every count of `CLKS_PER_BIT`-1. That sample lands mid-bit.
    - Bits are shifted in LSB first.
    - After 8 bits, go to PARITY (macro defined) or STOP.
  - PARITY: sample one bit, then go to STOP. Even parity: the XOR of 8 data bits and the parity bit must be 0.
  - STOP: sample one bit, then decide:
    - Sample 1 and parity ok: push the byte, then go to IDLE.
    - Sample 0: set `rxFrameErr`, drop the byte, go to WAIT_HIGH.
    - Sample 1 but parity mismatch: set `rxParityErr`, drop the byte, go to IDLE.
  - WAIT_HIGH: stay until the synchronized line is 1, then go to IDLE. This stops a held break from being read as repeated start bits.
- FIFO push:
  - When full, the byte is dropped and `rxOverrun` is set.
  - Fullness is evaluated before any same-cycle pop, so a push is dropped even if a pop happens in the same cycle.
- FIFO pop:
  - `rxRdEn` while `rxFfEmpty`=1 is ignored. No strobe, no state change.
  - `rxRdEn` while not empty: the next cycle gives `uartOutEn`=1 with `rxData` = the oldest entry, and the count decrements.
- Push and pop in the same cycle (not full, not empty): both take effect and the count is unchanged.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is one bit wider.
- Sticky flags:
  - Set has priority over `rxErrClr` in the same cycle.
  - Otherwise `rxErrClr`=1 clears all flags on the next edge.

## Timing
- Reset values:
  - `rxData`=0, `uartOutEn`=0, `rxFfEmpty`=1, `rxFfFull`=0.
  - All error flags 0, FSM in IDLE, pointers, count and counters 0.
- Reset asserted mid-frame: the partial byte is discarded, FIFO contents are lost, and all outputs return to reset values.
- Receive latency: `rxFfEmpty` falls 1 cycle after the STOP mid-bit sample edge. The push is registered.
- Read latency: exactly 1 cycle from `rxRdEn` to `uartOutEn`. `rxData` is registered and holds its value until the next pop.
- Back-to-back `rxRdEn` on consecutive cycles is legal. It yields consecutive strobes.
- `rxFfEmpty` and `rxFfFull` update on the same edge as the pointer change.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: 8E1 framing. The PARITY state is present and `rxParityErr` is live.
  - Undefined: 8N1 framing. The PARITY state and its logic are absent, and `rxParityErr` is tied to 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum `uart_rx_state_t`.
  - Constants for data bits (8) and the start-sample divisor (2).
  - Function `clks_per_bit(clkFreq, baudRate)`.
- Sub-module `uart_rx_sff`: a generic synchronous FIFO.
  - Ports: push, pop, write data, registered read data, read-valid strobe, empty, full.
  - Parameterized by width and depth.
- The top level holds the synchronizer, the deframing FSM and the sticky flags.

## Test plan
All tests use `CLK_FREQ`=50_000_000, `BAUD_RATE`=115200, giving `CLKS_PER_BIT`=434.
- Drive frame 0xA5 on `rxSerial`, then pulse `rxRdEn` → next cycle `uartOutEn`=1, `rxData`=0xA5, `rxFfEmpty`=1.
- Pulse `rxSerial` low for 100 clocks → no push, FSM back in IDLE, no error flags.
- Drive frame 0x3C with stop bit 0, hold the line low 2 bit times, release, then send 0x11 → `rxFrameErr`=1, only 0x11 in the FIFO.
- With `FIFO_DEPTH`=4, send 0x01..0x05 with no reads → `rxFfFull`=1 after the 4th byte, `rxOverrun`=1 after the 5th. Four pops return 0x01..0x04 in order.
- At count 2, align `rxRdEn` with the push edge → count stays 2 and both flags stay 0.
- Assert `rstB` during data bit 4 of a frame, release, then send 0x7E → only 0x7E is received and all outputs are at reset values during reset.
